// File: rtl/tmds_decoder.sv
`timescale 1ns/1ps
// tmds_decoder
// Receive-side TMDS symbol decoder for one colour channel. Registers each 10-bit
// symbol, classifies it as a control token or a data symbol, recovers the pixel byte
// or the 2-bit control value, and runs a word-alignment FSM (search / slip / locked)
// that pulses bitslip_out until symbol boundaries line up with the blanking tokens.
//
// Ports:
//   clk_in       pixel clock, one symbol per cycle
//   rst_n_in     synchronous active-low reset
//   tmds_in      received symbol {bit9, bit8, q[7:0]}
//   data_out     decoded pixel byte (valid when ve_out=1)
//   control_out  decoded control value (valid when ve_out=0 and locked_out=1)
//   ve_out       1 = data symbol, 0 = control token
//   locked_out   word alignment achieved
//   bitslip_out  one-cycle request to shift the deserializer by one bit
//   err_out      one-cycle running-disparity error pulse
//
// Optional feature: define TMDS_DECODER_DISPARITY_EN to build the running-disparity
// checker; without it err_out is tied low.
module tmds_decoder #(
  parameter int unsigned SEARCH_WINDOW = 2048,
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SLIP_WAIT     = 16
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       locked_out,
  output logic       bitslip_out,
  output logic       err_out
);

  localparam int unsigned WinW  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int unsigned RunW  = $clog2(CTRL_RUN + 1);
  localparam int unsigned WaitW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [WinW-1:0]  WinLast  = WinW'(SEARCH_WINDOW - 1);
  localparam logic [RunW-1:0]  RunFull  = RunW'(CTRL_RUN);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {StSearch, StSlip, StLocked} state_e;

  state_e           state_q, state_d;
  logic [9:0]       tmds_q;
  logic [RunW-1:0]  run_q, run_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             ve_q, ve_d;
  logic             locked_q, locked_d;
  logic             slip_q, slip_d;

  logic             is_ctrl;
  logic [1:0]       ctrl_val;
  logic [7:0]       q_bits;
  logic [7:0]       dec;

  // Stage-1 classification against the four control tokens.
  always_comb begin
    is_ctrl  = 1'b1;
    ctrl_val = 2'b00;
    case (tmds_q)
      10'b1101010100: ctrl_val = 2'b00;
      10'b0010101011: ctrl_val = 2'b01;
      10'b0101010100: ctrl_val = 2'b10;
      10'b1010101011: ctrl_val = 2'b11;
      default:        is_ctrl  = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit9), then the XOR/XNOR chain (bit8).
  always_comb begin
    q_bits = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
    dec    = 8'h00;
    dec[0] = q_bits[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = tmds_q[8] ? (q_bits[i] ^ q_bits[i-1]) : ~(q_bits[i] ^ q_bits[i-1]);
    end
  end

  // Alignment FSM next state and stage-2 output next state.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    wait_d  = wait_q;
    slip_d  = 1'b0;

    // run_d counts the current symbol too, so lock is declared on the CTRL_RUN-th token.
    if (!is_ctrl) begin
      run_d = '0;
    end else if (run_q == RunFull) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RunW'(1);
    end

    unique case (state_q)
      StSearch: begin
        if (run_d >= RunFull) begin
          state_d = StLocked;
          win_d   = '0;
        end else if (win_q == WinLast) begin
          state_d = StSlip;
          wait_d  = '0;
          slip_d  = 1'b1;
        end else begin
          win_d = win_q + WinW'(1);
        end
      end
      StSlip: begin
        // Tokens seen while the deserializer settles must not count toward lock.
        run_d = '0;
        if (wait_q == WaitLast) begin
          state_d = StSearch;
          win_d   = '0;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StLocked: begin
        if (is_ctrl) begin
          win_d = '0;
        end else if (win_q == WinLast) begin
          state_d = StSearch;
          win_d   = '0;
          run_d   = '0;
        end else begin
          win_d = win_q + WinW'(1);
        end
      end
      default: begin
        state_d = StSearch;
        win_d   = '0;
        run_d   = '0;
      end
    endcase

    // Gate on the next state so outputs and locked_out change in the same cycle.
    locked_d = (state_d == StLocked);
    ve_d     = locked_d & ~is_ctrl;
    data_d   = ve_d ? dec : 8'h00;
    ctrl_d   = (locked_d & is_ctrl) ? ctrl_val : 2'b00;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q  <= StSearch;
      tmds_q   <= '0;
      run_q    <= '0;
      win_q    <= '0;
      wait_q   <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      ve_q     <= 1'b0;
      locked_q <= 1'b0;
      slip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmds_q   <= tmds_in;
      run_q    <= run_d;
      win_q    <= win_d;
      wait_q   <= wait_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      ve_q     <= ve_d;
      locked_q <= locked_d;
      slip_q   <= slip_d;
    end
  end

  assign data_out    = data_q;
  assign control_out = ctrl_q;
  assign ve_out      = ve_q;
  assign locked_out  = locked_q;
  assign bitslip_out = slip_q;

`ifdef TMDS_DECODER_DISPARITY_EN
  logic signed [6:0] disp_q, disp_d;
  logic signed [6:0] disp_sum, sym_disp;
  logic [3:0]        ones;
  logic              err_q, err_d;

  // Disparity of a 10-bit symbol is ones - zeros = 2*ones - 10.
  always_comb begin
    ones     = 4'($countones(tmds_q));
    sym_disp = $signed({2'b00, ones, 1'b0}) - 7'sd10;
    disp_sum = disp_q + sym_disp;
    disp_d   = '0;
    err_d    = 1'b0;
    if (state_q == StLocked && !is_ctrl) begin
      if (disp_sum > 7'sd16 || disp_sum < -7'sd16) begin
        err_d = locked_d;
      end else begin
        disp_d = disp_sum;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      disp_q <= '0;
      err_q  <= 1'b0;
    end else begin
      disp_q <= disp_d;
      err_q  <= err_d;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
`timescale 1ns/1ps
// Self-checking bench for tmds_decoder: directed lock/decode/loss/reset/disparity
// scenarios plus randomized traffic, all checked every cycle against a symbol-level
// reference model; a misaligned stream is rotated back on each bitslip pulse.
module tb_tmds_decoder;

  localparam int SW    = 2048;
  localparam int CR    = 8;
  localparam int SWAIT = 16;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

`ifdef TMDS_DECODER_DISPARITY_EN
  localparam bit DispEn = 1'b1;
`else
  localparam bit DispEn = 1'b0;
`endif

  logic       clk_in;
  logic       rst_n_in;
  logic [9:0] tmds_in;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out;
  logic       locked_out;
  logic       bitslip_out;
  logic       err_out;

  tmds_decoder #(
    .SEARCH_WINDOW(SW),
    .CTRL_RUN     (CR),
    .SLIP_WAIT    (SWAIT)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .tmds_in    (tmds_in),
    .data_out   (data_out),
    .control_out(control_out),
    .ve_out     (ve_out),
    .locked_out (locked_out),
    .bitslip_out(bitslip_out),
    .err_out    (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int rot     = 0;
  int since_rst   = 0;
  int first_slip  = -1;
  int lock_at     = -1;

  logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit is_tok(input logic [9:0] s, output logic [1:0] v);
    v = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (s == tok_tab[k]) begin
        v = 2'(k);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] s, input int r);
    logic [19:0] d;
    d = {s, s};
    return d[19-r -: 10];
  endfunction

  // Inverse of the TMDS transition-minimising encode.
  function automatic logic [7:0] model_decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d = q ^ {q[6:0], 1'b0};
    if (!s[8]) d = d ^ 8'hFE;
    return d;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] x;
    logic [1:0] dv;
    do begin
      x = 10'($urandom);
    end while (is_tok(x, dv) || is_tok(rotl(x, 1), dv));
    return x;
  endfunction

  function automatic logic [9:0] stream_sym(input int i);
    return ((i % 100) < 12) ? TOK0 : rand_data();
  endfunction

  // ---------------- reference model (symbol level) ----------------
  localparam int MSearch = 0, MSlip = 1, MLocked = 2;
  int         m_mode;
  logic [9:0] m_s1;
  int         m_run, m_searched, m_gap, m_slip_left, m_disp;
  logic [7:0] e_data;
  logic [1:0] e_ctrl;
  logic       e_ve, e_lock, e_slip, e_err;

  task automatic model_step();
    logic [9:0] sym;
    logic [1:0] v;
    bit         tok;
    bit         was_locked;
    if (!rst_n_in) begin
      m_mode = MSearch; m_s1 = '0; m_run = 0; m_searched = 0; m_gap = 0;
      m_slip_left = 0; m_disp = 0;
      e_data = '0; e_ctrl = '0; e_ve = 0; e_lock = 0; e_slip = 0; e_err = 0;
      return;
    end
    sym  = m_s1;
    m_s1 = tmds_in;
    tok  = is_tok(sym, v);
    was_locked = (m_mode == MLocked);
    e_slip = 1'b0;
    e_err  = 1'b0;
    case (m_mode)
      MSearch: begin
        m_searched++;
        m_run = tok ? m_run + 1 : 0;
        if (m_run >= CR) begin
          m_mode = MLocked;
          m_gap  = 0;
        end else if (m_searched == SW) begin
          m_mode      = MSlip;
          m_slip_left = SWAIT;
          e_slip      = 1'b1;
        end
      end
      MSlip: begin
        m_slip_left--;
        if (m_slip_left == 0) begin
          m_mode = MSearch; m_searched = 0; m_run = 0;
        end
      end
      default: begin
        m_gap = tok ? 0 : m_gap + 1;
        if (m_gap == SW) begin
          m_mode = MSearch; m_searched = 0; m_run = 0;
        end
      end
    endcase
    if (DispEn) begin
      if (!was_locked || tok) begin
        m_disp = 0;
      end else begin
        m_disp += 2 * $countones(sym) - 10;
        if (m_disp > 16 || m_disp < -16) begin
          e_err  = (m_mode == MLocked);
          m_disp = 0;
        end
      end
    end
    e_lock = (m_mode == MLocked);
    e_ve   = e_lock && !tok;
    e_data = e_ve ? model_decode(sym) : 8'h00;
    e_ctrl = (e_lock && tok) ? v : 2'b00;
  endtask

  // Compare process: model advances on each edge, DUT sampled 1 ns later.
  always @(posedge clk_in) begin
    model_step();
    if (!rst_n_in) since_rst = 0;
    else since_rst++;
    #1;
    check("cycle {data,ctrl,ve,lock,slip,err}",
          32'({data_out, control_out, ve_out, locked_out, bitslip_out, err_out}),
          32'({e_data, e_ctrl, e_ve, e_lock, e_slip, e_err}));
    if (bitslip_out) begin
      rot = (rot + 9) % 10;
      if (first_slip < 0) first_slip = since_rst;
    end
    if (locked_out && lock_at < 0 && first_slip >= 0) lock_at = since_rst;
  end

  task automatic drive(input logic [9:0] s);
    @(negedge clk_in);
    tmds_in = rotl(s, rot);
  endtask

  initial begin
    rst_n_in = 1'b0;
    tmds_in  = '0;

    // Reset with random input: everything stays low.
    repeat (4) begin
      @(negedge clk_in);
      tmds_in = 10'($urandom);
      check("reset_outputs",
            32'({data_out, control_out, ve_out, locked_out, bitslip_out, err_out}), 32'(0));
    end
    rst_n_in = 1'b1;
    tmds_in  = 10'h000;

    // Lock and decode.
    repeat (8) drive(TOK0);
    drive(10'h100);
    check("pre_lock", 32'(locked_out), 32'(0));
    drive(10'h0FF);
    check("lock_rise", 32'(locked_out), 32'(1));
    drive(TOK0);
    check("decode_100", 32'({ve_out, data_out}), 32'({1'b1, 8'h00}));
    drive(TOK3);
    check("decode_0FF", 32'({ve_out, data_out}), 32'({1'b1, 8'hFF}));
    drive(TOK0);
    check("ctrl_00", 32'({locked_out, ve_out, control_out}), 32'({1'b1, 1'b0, 2'b00}));
    drive(TOK0);
    check("ctrl_11", 32'({ve_out, control_out}), 32'({1'b0, 2'b11}));
    drive(10'h2AA);
    drive(TOK0);
    drive(TOK0);
    check("decode_2AA", 32'({ve_out, data_out}), 32'({1'b1, 8'h01}));

    // Disparity: three +6 symbols overflow on the third.
    repeat (3) drive(10'h0FF);
    check("disp_first", 32'({err_out, data_out}), 32'({1'b0, 8'hFF}));
    drive(TOK0);
    check("disp_second", 32'(err_out), 32'(0));
    drive(TOK0);
    check("disp_third", 32'({err_out, data_out}), 32'({DispEn, 8'hFF}));
    drive(TOK0);
    check("disp_after", 32'(err_out), 32'(0));

    // Randomized traffic while locked.
    repeat (400) begin
      if ($urandom_range(3) == 0) drive(tok_tab[$urandom_range(3)]);
      else drive(10'($urandom));
    end

    // Lock loss after SW consecutive data symbols.
    repeat (8) drive(TOK0);
    repeat (SW + 1) drive(10'h100);
    check("loss_pre", 32'({locked_out, ve_out}), 32'({1'b1, 1'b1}));
    drive(10'h100);
    check("loss_fall", 32'({locked_out, ve_out, data_out}), 32'(0));

    // Reset while locked; relock needs a full run.
    repeat (10) drive(TOK0);
    check("relock_before_rst", 32'(locked_out), 32'(1));
    @(negedge clk_in);
    rst_n_in = 1'b0;
    tmds_in  = TOK0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tmds_in  = TOK0;
    check("rst_drop", 32'({locked_out, ve_out, control_out}), 32'(0));
    repeat (6) drive(TOK0);
    repeat (2) drive(10'h100);
    check("relock_partial", 32'(locked_out), 32'(0));
    repeat (10) drive(TOK0);
    check("relock_full", 32'(locked_out), 32'(1));

    // Misaligned stream: rotated by one bit until the DUT requests a slip.
    first_slip = -1;
    lock_at    = -1;
    @(negedge clk_in);
    rst_n_in = 1'b0;
    tmds_in  = '0;
    rot      = 1;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tmds_in  = rotl(stream_sym(0), rot);
    for (int i = 1; i < 2400; i++) drive(stream_sym(i));
    check("slip_cycle", 32'(first_slip), 32'(SW));
    check("lock_after_slip", 32'((lock_at > first_slip) && (lock_at - first_slip <= 100 + CR + SWAIT + 4)), 32'(1));
    check("aligned_locked", 32'(locked_out), 32'(1));

    repeat (3) drive(TOK0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
